// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, pixel/address types and fetch FSM states
package vga_pkg;
  localparam int H_VIS   = 640;
  localparam int V_VIS   = 480;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  typedef logic [7:0]  pixel_t;
  typedef logic [18:0] fb_addr_t;
  typedef enum logic {IDLE, FETCH} state_e;
endpackage

// File: rtl/vga_line_buffer.sv
// vga_line_buffer: two-bank line RAM, one write port and one registered read port
module vga_line_buffer
  import vga_pkg::*;
#(
  parameter int H_VIS = vga_pkg::H_VIS,
  parameter int CW    = $clog2(H_VIS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          wbank_i,
  input  logic [CW-1:0] wcol_i,
  input  logic [7:0]    wdata_i,
  input  logic          rbank_i,
  input  logic [CW-1:0] rcol_i,
  output logic [7:0]    rdata_o
);
  pixel_t mem_q [2][H_VIS];
  pixel_t rdata_q;
  // fill side writes returned fetch data; scanout side reads every cycle with one cycle latency
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wbank_i][wcol_i] <= wdata_i;
    rdata_q <= mem_q[rbank_i][rcol_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one frame-buffer SRAM port between line prefetch and host writes, drives scanout
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int H_VIS     = vga_pkg::H_VIS,
  parameter int V_VIS     = vga_pkg::V_VIS,
  parameter int V_TOTAL   = vga_pkg::V_TOTAL,
  parameter int HOST_SLOT = 8
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  input  logic        host_valid,
  input  logic [18:0] host_addr,
  input  logic [7:0]  host_data,
  output logic        host_ready,
  output logic [18:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pixel,
  output logic        underrun,
  input  logic        underrun_clr
);
  localparam int CW = $clog2(H_VIS);
  localparam int SW = HOST_SLOT > 2 ? $clog2(HOST_SLOT) : 1;
  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [9:0]    line_q, line_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          under_q, under_d;
  logic          run_q;
  logic          rvalid_q, fbank_q, vis_q;
  logic [CW-1:0] fcol_q, rcol;
  pixel_t        pixel_q, lb_rdata;
  logic          start, fetching, contend, host_win, fetch_go, last, vis;
  // fetch scheduling, SRAM arbitration and next-state; a restart cycle issues no read so the host may use it
  always_comb begin
    start      = x_pos == '0 && (y_pos == 10'(V_TOTAL - 1) || y_pos < 10'(V_VIS - 1));
    fetching   = state_q == FETCH && !start;
    contend    = fetching && host_valid;
    host_win   = contend && cnt_q == SW'(HOST_SLOT - 1);
    fetch_go   = fetching && !host_win;
    last       = col_q == CW'(H_VIS - 1);
    host_ready = run_q && host_valid && !fetch_go;
    mem_re     = fetch_go;
    mem_we     = host_ready;
    mem_addr   = fetch_go ? fb_addr_t'(line_q) * fb_addr_t'(H_VIS) + fb_addr_t'(col_q) :
                 host_ready ? host_addr : '0;
    mem_wdata  = host_ready ? host_data : '0;
    state_d    = start ? FETCH : (fetch_go && last) ? IDLE : state_q;
    col_d      = (start || (fetch_go && last)) ? '0 : fetch_go ? col_q + 1'b1 : col_q;
    line_d     = start ? (y_pos == 10'(V_TOTAL - 1) ? '0 : y_pos + 10'd1) : line_q;
    cnt_d      = (!contend || host_win) ? '0 : cnt_q + 1'b1;
    under_d    = (start && state_q == FETCH) ? 1'b1 : underrun_clr ? 1'b0 : under_q;
    vis        = x_pos < 10'(H_VIS) && y_pos < 10'(V_VIS);
    rcol       = vis ? x_pos[CW-1:0] : '0;
  end
  // control state; run_q keeps the host port closed until the first clock after reset release
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      under_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      under_q <= under_d;
      run_q   <= 1'b1;
    end
  end
  // track the read in flight so its data lands at the issuing column, and delay the blank mask to match the RAM read
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 1'b0;
      fcol_q   <= '0;
      fbank_q  <= 1'b0;
      vis_q    <= 1'b0;
      pixel_q  <= '0;
    end else begin
      rvalid_q <= fetch_go;
      fcol_q   <= col_q;
      fbank_q  <= line_q[0];
      vis_q    <= vis;
      pixel_q  <= vis_q ? lb_rdata : '0;
    end
  end
  vga_line_buffer #(.H_VIS(H_VIS), .CW(CW)) u_lb (
    .clk     (vga_clk),
    .we_i    (rvalid_q),
    .wbank_i (fbank_q),
    .wcol_i  (fcol_q),
    .wdata_i (mem_rdata),
    .rbank_i (y_pos[0]),
    .rcol_i  (rcol),
    .rdata_o (lb_rdata)
  );
  assign pixel    = pixel_q;
  assign underrun = under_q;
endmodule
